// File: rtl/led_pkg.sv
// Shared types for the LED frame buffer.
//   rgb_t      : one LED colour, packed {r, g, b}, 8 bits each (r in the MSBs).
//   colour constants for common test and idle patterns.
//   fb_state_e : frame-launch FSM states.
package led_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t Black   = 24'h000000;
  localparam rgb_t Red     = 24'hff0000;
  localparam rgb_t Green   = 24'h00ff00;
  localparam rgb_t Blue    = 24'h0000ff;
  localparam rgb_t Yellow  = 24'hffff00;
  localparam rgb_t Cyan    = 24'h00ffff;
  localparam rgb_t Magenta = 24'hff00ff;
  localparam rgb_t White   = 24'hffffff;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReq,
    StSend
  } fb_state_e;

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered LED frame store feeding an LED chain driver.
// Colour writes land in a back bank; a commit marks the back bank as a complete frame, which is
// copied into the front bank and sent with exactly one start/done transfer. The front bank only
// changes in the load cycle, so led_rgb is stable for the whole transfer.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_rgb : back-bank write port (addresses >= LEDS are ignored)
//   commit            : back bank holds a complete frame
//   led_rgb           : front bank, LED 0 in the MSBs
//   start / done      : driver handshake (done high = driver idle)
//   busy              : frame pending or transfer in flight
//   dropped           : saturating count of frames overwritten before being sent
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int unsigned LEDS   = 50,
  parameter int unsigned DROP_W = 8,
  localparam int unsigned AW    = (LEDS > 1) ? $clog2(LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [23:0]         wr_rgb,
  input  logic                commit,
  output logic [24*LEDS-1:0]  led_rgb,
  output logic                start,
  input  logic                done,
  output logic                busy,
  output logic [DROP_W-1:0]   dropped
);

  rgb_t              back_q  [LEDS];
  rgb_t              front_q [LEDS];
  fb_state_e         state_q, state_d;
  logic              start_q, start_d;
  logic              pending_q;
  logic [DROP_W-1:0] dropped_q;
  logic              wr_ok;
  logic              drop_hit;

  assign wr_ok = wr_en && (32'(wr_addr) < LEDS);

  // A commit in the load cycle refills pending for the next frame rather than overwriting an
  // unsent one, so it is not a drop.
  assign drop_hit = commit && pending_q && (state_q != StLoad) && (dropped_q != '1);

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    unique case (state_q)
      StIdle: if (pending_q && done) state_d = StLoad;
      StLoad: begin
        state_d = StReq;
        start_d = 1'b1;
      end
      StReq: if (!done) begin
        state_d = StSend;
        start_d = 1'b0;
      end
      StSend: if (done) state_d = StIdle;
      default: begin
        state_d = StIdle;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LEDS); i++) begin
        back_q[i]  <= Black;
        front_q[i] <= Black;
      end
      state_q   <= StIdle;
      start_q   <= 1'b0;
      pending_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      if (wr_ok) back_q[wr_addr] <= rgb_t'(wr_rgb);
      // Front takes the pre-edge back bank; a write on this edge belongs to the next frame.
      if (state_q == StLoad) begin
        for (int i = 0; i < int'(LEDS); i++) front_q[i] <= back_q[i];
      end
      if (commit) begin
        pending_q <= 1'b1;
      end else if (state_q == StLoad) begin
        pending_q <= 1'b0;
      end
      if (drop_hit) dropped_q <= dropped_q + DROP_W'(1);
    end
  end

  for (genvar i = 0; i < LEDS; i++) begin : g_pack
    assign led_rgb[24*(LEDS-i)-1 -: 24] = front_q[i];
  end

  assign start   = start_q;
  assign busy    = pending_q || (state_q != StIdle);
  assign dropped = dropped_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer (LEDS = 5). A second instance with a 2-bit drop
// counter shares all stimulus to exercise saturation.
module tb_led_frame_buffer;

  localparam int unsigned N = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_addr = '0;
  logic [23:0]    wr_rgb = '0;
  logic           commit = 1'b0;
  logic           done = 1'b1;
  logic [119:0]   led_rgb, led_rgb_s;
  logic           start, start_s, busy, busy_s;
  logic [7:0]     dropped;
  logic [1:0]     dropped_s;

  led_frame_buffer #(.LEDS(N), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb), .commit(commit),
    .led_rgb(led_rgb), .start(start), .done(done), .busy(busy), .dropped(dropped)
  );

  led_frame_buffer #(.LEDS(N), .DROP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb), .commit(commit),
    .led_rgb(led_rgb_s), .start(start_s), .done(done), .busy(busy_s), .dropped(dropped_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count rising edges of start, sampled away from the active edge.
  int   start_cnt = 0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (start && !start_prev) start_cnt++;
    start_prev = start;
  end

  // Reference model: frame contents, pending flag and drop count at transaction level.
  logic [23:0] m_back  [N];
  logic [23:0] m_front [N];
  bit          m_pending = 0;
  int          m_dropped = 0;

  function automatic logic [119:0] pack_front();
    logic [119:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) r[24*(int'(N)-i)-1 -: 24] = m_front[i];
    return r;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_back[i]  = '0;
      m_front[i] = '0;
    end
    m_pending = 0;
    m_dropped = 0;
  endtask

  task automatic model_commit();
    if (m_pending) m_dropped++;
    else m_pending = 1;
  endtask

  task automatic model_load();
    for (int i = 0; i < int'(N); i++) m_front[i] = m_back[i];
    m_pending = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int addr, input logic [23:0] rgb, input bit with_commit);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_rgb  = rgb;
    commit  = with_commit;
    if (addr < int'(N)) m_back[addr] = rgb;
    if (with_commit) model_commit();
    tick();
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    model_commit();
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20 && !start; i++) tick();
    check(tag, start, 1);
  endtask

  // Driver side: keep done high for hold cycles, accept, then finish.
  task automatic finish_xfer(input int hold);
    logic [119:0] f;
    f = pack_front();
    repeat (hold) tick();
    done = 1'b0;
    tick();
    check("req_drop", start, 0);
    repeat ($urandom_range(1, 3)) tick();
    check("send_stable", led_rgb, f);
    done = 1'b1;
    tick();
  endtask

  logic [119:0] prev_frame;
  logic [23:0]  c;
  int           n;
  int           a;

  initial begin
    model_reset();
    // 1: reset state, then a full frame and commit-to-start latency
    tick();
    tick();
    rst = 1'b0;
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_led", led_rgb, 0);
    check("rst_dropped", dropped, 0);
    repeat (4) tick();
    check("rst_no_start", start_cnt, 0);

    write(0, 24'hff0000, 0);
    write(1, 24'h00ff00, 0);
    write(2, 24'h0000ff, 0);
    write(3, 24'hffffff, 0);
    write(4, 24'h000000, 0);
    do_commit();
    check("lat1", start, 0);
    check("busy_pending", busy, 1);
    tick();
    check("lat2", start, 0);
    tick();
    check("lat3", start, 1);
    model_load();
    check("frame1_const", led_rgb, 120'hff0000_00ff00_0000ff_ffffff_000000);
    check("frame1_model", led_rgb, pack_front());

    // 2: start held while done stays high, drops after done low
    repeat (4) begin
      tick();
      check("start_hold", start, 1);
    end
    done = 1'b0;
    tick();
    check("start_fall", start, 0);
    check("busy_send", busy, 1);
    done = 1'b1;
    tick();
    check("busy_idle", busy, 0);
    n = start_cnt;
    repeat (6) tick();
    check("no_restart", start_cnt, n);

    // 3: new frame written and committed during SEND
    do_commit();
    wait_start("s3_start");
    model_load();
    done = 1'b0;
    tick();
    prev_frame = pack_front();
    write(2, 24'h123456, 1);
    repeat (3) begin
      tick();
      check("send_frozen", led_rgb, prev_frame);
    end
    n = start_cnt;
    done = 1'b1;
    tick();
    wait_start("s3_follow");
    model_load();
    check("s3_frame", led_rgb, pack_front());
    check("s3_led2", led_rgb[71:48], 24'h123456);
    finish_xfer(1);
    repeat (5) tick();
    check("s3_one_start", start_cnt, n + 1);

    // 4: drops during one SEND, and saturation on the narrow counter
    do_commit();
    wait_start("s4_start");
    model_load();
    done = 1'b0;
    tick();
    repeat (3) do_commit();
    check("drop2", dropped, m_dropped);
    check("drop2_const", dropped, 2);
    check("drop2_sat", dropped_s, sat3(m_dropped));
    repeat (5) do_commit();
    check("drop7", dropped, m_dropped);
    check("drop_sat", dropped_s, 3);
    n = start_cnt;
    done = 1'b1;
    tick();
    wait_start("s4_follow");
    model_load();
    check("s4_frame", led_rgb, pack_front());
    finish_xfer(1);
    repeat (6) tick();
    check("s4_single", start_cnt, n + 1);
    check("s4_idle", busy, 0);

    // 5: out-of-range writes ignored; write with commit is included
    prev_frame = pack_front();
    write(5, 24'hdead01, 0);
    write(7, 24'hbeef02, 0);
    do_commit();
    wait_start("s5_start");
    model_load();
    check("oob_ignored", led_rgb, prev_frame);
    finish_xfer($urandom_range(0, 2));
    a = $urandom_range(0, 4);
    c = 24'($urandom);
    write(a, c, 1);
    wait_start("s5b_start");
    model_load();
    check("wr_commit_frame", led_rgb, pack_front());
    check("wr_commit_led", led_rgb[24*(int'(N)-a)-1 -: 24], c);
    finish_xfer(0);

    // Write and commit landing in the load cycle belong to the next frame, not a drop
    do_commit();
    tick();
    model_load();
    prev_frame = pack_front();
    c = 24'($urandom);
    write(0, c, 1);
    check("load_start", start, 1);
    check("load_frame", led_rgb, prev_frame);
    check("load_no_drop", dropped, m_dropped);
    finish_xfer(1);
    wait_start("load_follow");
    model_load();
    check("load_next", led_rgb, pack_front());
    finish_xfer(0);

    // Random frames
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) write($urandom_range(0, 7), 24'($urandom), 0);
      if ($urandom_range(0, 1) == 1) write($urandom_range(0, 7), 24'($urandom), 1);
      else do_commit();
      wait_start("rnd_start");
      model_load();
      check("rnd_frame", led_rgb, pack_front());
      check("rnd_busy", busy, 1);
      finish_xfer($urandom_range(0, 3));
    end
    check("rnd_dropped", dropped, m_dropped);

    // 6: reset in REQ
    do_commit();
    wait_start("s6_start");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("s6_start0", start, 0);
    check("s6_led0", led_rgb, 0);
    check("s6_drop0", dropped, 0);
    check("s6_drop0_sat", dropped_s, 0);
    check("s6_busy0", busy, 0);
    n = start_cnt;
    repeat (6) tick();
    check("s6_no_start", start_cnt, n);
    do_commit();
    wait_start("s6_restart");
    model_load();
    check("s6_black", led_rgb, pack_front());
    finish_xfer(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
